// File: rtl/conv_pkg.sv
// Shared constants for the convolution PE scratchpad address generators:
// default widths and the write-side FSM state encoding.
package conv_pkg;

  localparam int unsigned DEF_FILTER_SIZE_WIDTH = 3;
  localparam int unsigned DEF_STRIDE_WIDTH      = 2;
  localparam int unsigned DEF_IFMAP_ADDR_WIDTH  = 4;
  localparam int unsigned DEF_IFMAP_DEPTH       = 16;
  localparam int unsigned DEF_FILTER_ADDR_WIDTH = 5;

  localparam int unsigned STATE_WIDTH = 2;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE        = 2'd0;
  localparam logic [STATE_WIDTH-1:0] ST_LOAD_FILTER = 2'd1;
  localparam logic [STATE_WIDTH-1:0] ST_LOAD_IFMAP  = 2'd2;
  localparam logic [STATE_WIDTH-1:0] ST_ROW_DONE    = 2'd3;

endpackage

// File: rtl/circ_ptr.sv
// Modulo-DEPTH pointer with clear, load, increment-by-1 and advance-by-k.
// Priority: clr > load > adv > inc. k is expected to be below DEPTH.
module circ_ptr #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned K_WIDTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  adv,
  input  logic [K_WIDTH-1:0]    k,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam int unsigned SW = ((K_WIDTH > ADDR_WIDTH) ? K_WIDTH : ADDR_WIDTH) + 1;

  logic [SW-1:0]         sum_k_c;
  logic [SW-1:0]         sum_1_c;
  logic [ADDR_WIDTH-1:0] ptr_nxt_c;

  // Single conditional subtract is enough since both steps are below DEPTH.
  always_comb begin
    sum_k_c = SW'(ptr) + SW'(k);
    sum_1_c = SW'(ptr) + SW'(1);
    if (sum_k_c >= SW'(DEPTH)) sum_k_c = sum_k_c - SW'(DEPTH);
    if (sum_1_c >= SW'(DEPTH)) sum_1_c = sum_1_c - SW'(DEPTH);

    ptr_nxt_c = ptr;
    if (clr)       ptr_nxt_c = '0;
    else if (load) ptr_nxt_c = load_val;
    else if (adv)  ptr_nxt_c = ADDR_WIDTH'(sum_k_c);
    else if (inc)  ptr_nxt_c = ADDR_WIDTH'(sum_1_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt_c;
  end

endmodule

// File: rtl/ifmap_write_address_generator.sv
// Write-side address generator: linear filter region, circular IFMap region.
// Optional WAG_OVERFLOW_CHECK_EN adds a sticky err output for release underflow / fptr overrun.
module ifmap_write_address_generator
  import conv_pkg::*;
#(
  parameter int unsigned FILTER_SIZE_WIDTH = DEF_FILTER_SIZE_WIDTH,
  parameter int unsigned STRIDE_WIDTH      = DEF_STRIDE_WIDTH,
  parameter int unsigned IFMAP_ADDR_WIDTH  = DEF_IFMAP_ADDR_WIDTH,
  parameter int unsigned IFMAP_DEPTH       = DEF_IFMAP_DEPTH,
  parameter int unsigned FILTER_ADDR_WIDTH = DEF_FILTER_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_addr,
  input  logic                         start,
  input  logic [FILTER_SIZE_WIDTH-1:0] filter_size,
  input  logic [STRIDE_WIDTH-1:0]      stride,
  input  logic                         filter_valid,
  input  logic                         filter_last,
  output logic                         filter_ready,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  input  logic                         win_release,
  input  logic                         row_consumed,
  output logic                         wen_Filter,
  output logic [FILTER_ADDR_WIDTH-1:0] waddr_Filter,
  output logic                         wen_IFMap,
  output logic [IFMAP_ADDR_WIDTH-1:0]  waddr_IFMap,
  output logic [FILTER_ADDR_WIDTH-1:0] end_filters,
  output logic [IFMAP_ADDR_WIDTH-1:0]  start_data,
  output logic [IFMAP_ADDR_WIDTH-1:0]  end_data,
  output logic                         valid_end,
  output logic                         win_avail,
`ifdef WAG_OVERFLOW_CHECK_EN
  output logic                         err,
`endif
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CW = IFMAP_ADDR_WIDTH + 1;

  logic [STATE_WIDTH-1:0]       state, state_nxt;
  logic [FILTER_ADDR_WIDTH-1:0] fptr, fptr_nxt;
  logic [FILTER_ADDR_WIDTH-1:0] end_filters_nxt;
  logic [IFMAP_ADDR_WIDTH-1:0]  end_data_nxt;
  logic [IFMAP_ADDR_WIDTH-1:0]  wptr, wptr_inc_c, wptr_nxt_c;
  logic [CW-1:0]                count, count_nxt;
  logic [CW-1:0]                avail_c, stride_c;
  logic                         valid_end_nxt, full_nxt, empty_nxt, win_avail_nxt;
  logic                         rc_ok_c, rel_ok_c, sat_c;

  assign filter_ready = (state == ST_LOAD_FILTER);
  assign in_ready     = (state == ST_LOAD_IFMAP) && !full;
  assign wen_Filter   = filter_valid && filter_ready;
  assign wen_IFMap    = in_valid && in_ready;
  assign waddr_Filter = fptr;
  assign waddr_IFMap  = wptr;

  // A row_consumed in ROW_DONE wins over a coincident release.
  assign rc_ok_c  = row_consumed && (state == ST_ROW_DONE);
  assign rel_ok_c = win_release &&
                    ((state == ST_LOAD_IFMAP) || ((state == ST_ROW_DONE) && !row_consumed));
  assign avail_c  = count + CW'(wen_IFMap);
  assign stride_c = CW'(stride);
  assign sat_c    = rel_ok_c && (stride_c > avail_c);

  assign wptr_inc_c = (wptr == IFMAP_ADDR_WIDTH'(IFMAP_DEPTH - 1)) ? '0
                                                                   : wptr + IFMAP_ADDR_WIDTH'(1);
  assign wptr_nxt_c = wen_IFMap ? wptr_inc_c : wptr;

  circ_ptr #(
    .ADDR_WIDTH (IFMAP_ADDR_WIDTH),
    .DEPTH      (IFMAP_DEPTH),
    .K_WIDTH    (STRIDE_WIDTH)
  ) u_wptr (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (clr_addr),
    .load     (1'b0),
    .load_val ('0),
    .adv      (1'b0),
    .k        ('0),
    .inc      (wen_IFMap),
    .ptr      (wptr)
  );

  // Saturating release snaps the oldest address to the post-write pointer.
  circ_ptr #(
    .ADDR_WIDTH (IFMAP_ADDR_WIDTH),
    .DEPTH      (IFMAP_DEPTH),
    .K_WIDTH    (STRIDE_WIDTH)
  ) u_start_ptr (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (clr_addr),
    .load     (rc_ok_c || sat_c),
    .load_val (wptr_nxt_c),
    .adv      (rel_ok_c && !sat_c),
    .k        (stride),
    .inc      (1'b0),
    .ptr      (start_data)
  );

  always_comb begin
    state_nxt       = state;
    fptr_nxt        = fptr;
    end_filters_nxt = end_filters;
    end_data_nxt    = end_data;
    valid_end_nxt   = valid_end;
    count_nxt       = count;

    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD_FILTER;
      end
      ST_LOAD_FILTER: begin
        if (wen_Filter) begin
          fptr_nxt = fptr + FILTER_ADDR_WIDTH'(1);
          if (filter_last) begin
            end_filters_nxt = fptr;
            state_nxt       = ST_LOAD_IFMAP;
          end
        end
      end
      ST_LOAD_IFMAP: begin
        if (wen_IFMap) begin
          end_data_nxt = wptr;
          if (in_last) begin
            valid_end_nxt = 1'b1;
            state_nxt     = ST_ROW_DONE;
          end
        end
      end
      ST_ROW_DONE: begin
        if (rc_ok_c) begin
          count_nxt     = '0;
          valid_end_nxt = 1'b0;
          state_nxt     = ST_LOAD_IFMAP;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (rel_ok_c)       count_nxt = sat_c ? '0 : avail_c - stride_c;
    else if (wen_IFMap) count_nxt = avail_c;

    if (clr_addr) begin
      state_nxt       = ST_IDLE;
      fptr_nxt        = '0;
      end_filters_nxt = '0;
      end_data_nxt    = '0;
      valid_end_nxt   = 1'b0;
      count_nxt       = '0;
    end

    full_nxt      = (count_nxt == CW'(IFMAP_DEPTH));
    empty_nxt     = (count_nxt == '0);
    win_avail_nxt = !clr_addr && (count_nxt >= CW'(filter_size));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      fptr        <= '0;
      end_filters <= '0;
      end_data    <= '0;
      valid_end   <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      win_avail   <= 1'b0;
    end else begin
      state       <= state_nxt;
      fptr        <= fptr_nxt;
      end_filters <= end_filters_nxt;
      end_data    <= end_data_nxt;
      valid_end   <= valid_end_nxt;
      count       <= count_nxt;
      full        <= full_nxt;
      empty       <= empty_nxt;
      win_avail   <= win_avail_nxt;
    end
  end

`ifdef WAG_OVERFLOW_CHECK_EN
  logic err_nxt;

  // Sticky: underflowing release, or a non-last filter beat with fptr at its top.
  always_comb begin
    err_nxt = err || sat_c ||
              ((state == ST_LOAD_FILTER) && filter_valid && (fptr == '1) && !filter_last);
    if (clr_addr) err_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= err_nxt;
  end
`endif

endmodule

// File: tb/tb_ifmap_write_address_generator.sv
// Self-checking bench: directed scenarios then randomized traffic, checked
// against an arithmetic occupancy/pointer model of the write-side generator.
module tb_ifmap_write_address_generator;

  localparam int DEPTH = 16;
  localparam int FDEPTH = 32;

  logic       clk = 1'b0;
  logic       rst, clr_addr, start;
  logic [2:0] filter_size;
  logic [1:0] stride;
  logic       filter_valid, filter_last, filter_ready;
  logic       in_valid, in_last, in_ready;
  logic       win_release, row_consumed;
  logic       wen_Filter, wen_IFMap;
  logic [4:0] waddr_Filter, end_filters;
  logic [3:0] waddr_IFMap, start_data, end_data;
  logic       valid_end, win_avail, full, empty;
`ifdef WAG_OVERFLOW_CHECK_EN
  logic       err;
`endif

  ifmap_write_address_generator dut (
    .clk          (clk),
    .rst          (rst),
    .clr_addr     (clr_addr),
    .start        (start),
    .filter_size  (filter_size),
    .stride       (stride),
    .filter_valid (filter_valid),
    .filter_last  (filter_last),
    .filter_ready (filter_ready),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .win_release  (win_release),
    .row_consumed (row_consumed),
    .wen_Filter   (wen_Filter),
    .waddr_Filter (waddr_Filter),
    .wen_IFMap    (wen_IFMap),
    .waddr_IFMap  (waddr_IFMap),
    .end_filters  (end_filters),
    .start_data   (start_data),
    .end_data     (end_data),
    .valid_end    (valid_end),
    .win_avail    (win_avail),
`ifdef WAG_OVERFLOW_CHECK_EN
    .err          (err),
`endif
    .full         (full),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 filter load, 2 ifmap load, 3 row done.
  int m_state, m_fptr, m_endf, m_wptr, m_sd, m_ed, m_cnt, m_ve, m_wa, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_fptr = 0; m_endf = 0; m_wptr = 0; m_sd = 0;
    m_ed = 0; m_cnt = 0; m_ve = 0; m_wa = 0; m_err = 0;
  endtask

  task automatic idle_inputs();
    clr_addr = 0; start = 0; filter_valid = 0; filter_last = 0;
    in_valid = 0; in_last = 0; win_release = 0; row_consumed = 0;
  endtask

  task automatic model_update();
    int fr, ir, wf, wi, rc, rl, avail, nw;
    if (clr_addr) begin
      m_reset();
      return;
    end
    fr = (m_state == 1);
    ir = (m_state == 2) && (m_cnt != DEPTH);
    wf = int'(filter_valid) & fr;
    wi = int'(in_valid) & ir;
    rc = int'(row_consumed) & int'(m_state == 3);
    rl = int'(win_release) & int'((m_state == 2) || (m_state == 3 && !row_consumed));
    avail = m_cnt + wi;
    nw = (m_wptr + wi) % DEPTH;
    if (rl != 0 && int'(stride) > avail) m_err = 1;
    if (m_state == 1 && filter_valid && m_fptr == FDEPTH - 1 && !filter_last) m_err = 1;
    case (m_state)
      0: if (start) m_state = 1;
      1: if (wf != 0) begin
           if (filter_last) begin m_endf = m_fptr; m_state = 2; end
           m_fptr = (m_fptr + 1) % FDEPTH;
         end
      2: if (wi != 0) begin
           m_ed = m_wptr;
           if (in_last) begin m_ve = 1; m_state = 3; end
         end
      default: if (rc != 0) begin m_sd = m_wptr; m_cnt = 0; m_ve = 0; m_state = 2; end
    endcase
    m_wptr = nw;
    if (rl != 0) begin
      if (int'(stride) > avail) begin m_cnt = 0; m_sd = nw; end
      else begin m_cnt = avail - int'(stride); m_sd = (m_sd + int'(stride)) % DEPTH; end
    end else if (rc == 0) m_cnt = avail;
    m_wa = (m_cnt >= int'(filter_size)) ? 1 : 0;
  endtask

  task automatic check_regs();
    check("end_filters", 32'(end_filters), 32'(m_endf));
    check("start_data",  32'(start_data),  32'(m_sd));
    check("end_data",    32'(end_data),    32'(m_ed));
    check("valid_end",   32'(valid_end),   32'(m_ve));
    check("win_avail",   32'(win_avail),   32'(m_wa));
    check("full",        32'(full),        32'(m_cnt == DEPTH));
    check("empty",       32'(empty),       32'(m_cnt == 0));
`ifdef WAG_OVERFLOW_CHECK_EN
    check("err",         32'(err),         32'(m_err));
`endif
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic step();
    logic exp_fr, exp_ir;
    #1;
    exp_fr = (m_state == 1);
    exp_ir = (m_state == 2) && (m_cnt != DEPTH);
    check("filter_ready", 32'(filter_ready), 32'(exp_fr));
    check("in_ready",     32'(in_ready),     32'(exp_ir));
    check("wen_Filter",   32'(wen_Filter),   32'(filter_valid && exp_fr));
    check("wen_IFMap",    32'(wen_IFMap),    32'(in_valid && exp_ir));
    check("waddr_Filter", 32'(waddr_Filter), 32'(m_fptr));
    check("waddr_IFMap",  32'(waddr_IFMap),  32'(m_wptr));
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_regs();
  endtask

  initial begin
    idle_inputs();
    filter_size = 3'd4;
    stride = 2'd3;
    rst = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_regs();

    // Filter load: 24 beats, last on the 24th.
    start = 1; step(); start = 0;
    for (int i = 0; i < 24; i++) begin
      filter_valid = 1; filter_last = (i == 23); step();
    end
    idle_inputs();
    check("end_filters_23", 32'(end_filters), 32'd23);

    // Fill the IFMap buffer; the 17th beat must be refused.
    for (int i = 0; i < 17; i++) begin
      in_valid = 1; step();
    end
    idle_inputs();
    check("full_after_16", 32'(full), 32'd1);
    #1 check("in_ready_when_full", 32'(in_ready), 32'd0);
    @(negedge clk);

    // Fresh row: 14 writes then 4 releases of stride 3.
    clr_addr = 1; step(); clr_addr = 0;
    start = 1; step(); start = 0;
    filter_valid = 1; filter_last = 1; step(); idle_inputs();
    for (int i = 0; i < 14; i++) begin in_valid = 1; step(); end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin win_release = 1; step(); end
    idle_inputs();
    check("start_data_12", 32'(start_data), 32'd12);
    check("win_avail_cnt2", 32'(win_avail), 32'd0);

    // Wrap through the end of the buffer, then a release coincident with a write.
    for (int i = 0; i < 6; i++) begin in_valid = 1; step(); end
    idle_inputs();
    check("end_data_wrap", 32'(end_data), 32'd3);
    in_valid = 1; win_release = 1; step(); idle_inputs();
    check("start_data_15", 32'(start_data), 32'd15);
    check("win_avail_cnt6", 32'(win_avail), 32'd1);

    // End of row on the 9th word, then row_consumed.
    for (int i = 0; i < 9; i++) begin in_valid = 1; in_last = (i == 8); step(); end
    idle_inputs();
    check("valid_end_set", 32'(valid_end), 32'd1);
    in_valid = 1; step(); idle_inputs();
    row_consumed = 1; step(); idle_inputs();
    check("start_data_row", 32'(start_data), 32'd14);
    check("valid_end_clear", 32'(valid_end), 32'd0);
    check("empty_row", 32'(empty), 32'd1);

    // Saturating release: count 1, stride 3.
    in_valid = 1; step(); idle_inputs();
    win_release = 1; stride = 2'd3; step(); idle_inputs();
    check("start_data_sat", 32'(start_data), 32'd15);
    check("empty_sat", 32'(empty), 32'd1);
`ifdef WAG_OVERFLOW_CHECK_EN
    check("err_sat", 32'(err), 32'd1);
`endif

    // Asynchronous reset in the middle of an IFMap load.
    for (int i = 0; i < 3; i++) begin in_valid = 1; step(); end
    #2 rst = 1'b0;
    #1;
    check("rst_end_data", 32'(end_data), 32'd0);
    check("rst_waddr_IFMap", 32'(waddr_IFMap), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_end_filters", 32'(end_filters), 32'd0);
    m_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    check_regs();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      clr_addr     = ($urandom_range(63) == 0);
      start        = ($urandom_range(3) == 0);
      filter_valid = $urandom_range(1) == 1;
      filter_last  = ($urandom_range(7) == 0);
      in_valid     = $urandom_range(1) == 1;
      in_last      = ($urandom_range(15) == 0);
      win_release  = ($urandom_range(3) == 0);
      row_consumed = ($urandom_range(3) == 0);
      stride       = 2'($urandom_range(3));
      filter_size  = 3'($urandom_range(7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
